// File: rtl/led_status_sequencer.sv
// Turns receiver level strobes and the fault flag into active-high LED requests:
// boot chase, idle heartbeat, strength bar graph, signal-lost blink and fault blink.
module led_status_sequencer #(
    parameter int CLK_FREQ           = 12000000,
    parameter int TICK_HZ            = 100,
    parameter int LEVEL_W            = 4,
    parameter int BOOT_STEPS         = 8,
    parameter int HB_PERIOD_TICKS    = 100,
    parameter int HB_ON_TICKS        = 10,
    parameter int LOST_TIMEOUT_TICKS = 50,
    parameter int LOST_HOLD_TICKS    = 100,
    parameter int BLINK_TICKS        = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               level_valid_i,
    input  logic [LEVEL_W-1:0] level_i,
    input  logic               fault_i,
    output logic [3:0]         led_o,
    output logic               led0_r_o,
    output logic               led0_g_o,
    output logic               led0_b_o
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PRESC_W  = $clog2(TICK_DIV);
    localparam int MAX_AB   = (BOOT_STEPS > HB_PERIOD_TICKS) ? BOOT_STEPS : HB_PERIOD_TICKS;
    localparam int MAX_CD   = (LOST_TIMEOUT_TICKS > LOST_HOLD_TICKS) ? LOST_TIMEOUT_TICKS : LOST_HOLD_TICKS;
    localparam int TCNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TCNT_RAW = $clog2(TCNT_MAX + 1);
    // At least two bits so the boot chase can index its four positions.
    localparam int TCNT_W   = (TCNT_RAW < 2) ? 2 : TCNT_RAW;
    localparam int BLINK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_TRACK,
        ST_LOST,
        ST_FAULT
    } state_t;

    logic [PRESC_W-1:0] presc_reg;
    logic               tick;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_reg;
    state_t             state_reg;
    logic [TCNT_W-1:0]  tcnt_reg;
    logic [3:0]         bars_reg;
    logic [3:0]         led_reg;
    logic               r_reg;
    logic               g_reg;
    logic               b_reg;
    logic [3:0]         therm;
    logic [2:0]         bar_count;
    logic               level_nz;

    assign tick      = (presc_reg == PRESC_W'(TICK_DIV - 1));
    assign level_nz  = |level_i;
    assign bar_count = {1'b0, level_i[LEVEL_W-1 -: 2]} + 3'd1;

    // Thermometer code: LED gi lit when the bar count exceeds gi.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_therm
            assign therm[gi] = (bar_count > 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt_reg == BLINK_W'(BLINK_TICKS - 1)) begin
                blink_cnt_reg <= '0;
                blink_reg     <= ~blink_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_BOOT;
            tcnt_reg  <= '0;
            bars_reg  <= '0;
            led_reg   <= '0;
            r_reg     <= 1'b0;
            g_reg     <= 1'b0;
            b_reg     <= 1'b0;
        end else begin
            // Decode uses pre-update values, so outputs trail state by one cycle.
            led_reg <= '0;
            r_reg   <= 1'b0;
            g_reg   <= 1'b0;
            b_reg   <= 1'b0;
            case (state_reg)
                ST_BOOT: begin
                    led_reg <= 4'b0001 << tcnt_reg[1:0];
                    b_reg   <= 1'b1;
                end
                ST_IDLE: begin
                    g_reg <= (tcnt_reg < TCNT_W'(HB_ON_TICKS));
                end
                ST_TRACK: begin
                    led_reg <= bars_reg;
                    g_reg   <= 1'b1;
                    r_reg   <= (bars_reg != 4'b1111);
                end
                ST_LOST: begin
                    led_reg <= bars_reg & {4{blink_reg}};
                    r_reg   <= blink_reg;
                end
                ST_FAULT: begin
                    r_reg <= blink_reg;
                end
                default: ;
            endcase

            if (fault_i) begin
                if (state_reg != ST_FAULT) begin
                    state_reg <= ST_FAULT;
                    tcnt_reg  <= '0;
                end else if (tick) begin
                    tcnt_reg <= tcnt_reg + TCNT_W'(1);
                end
            end else begin
                case (state_reg)
                    ST_BOOT: begin
                        if (tick) begin
                            if (tcnt_reg == TCNT_W'(BOOT_STEPS - 1)) begin
                                state_reg <= ST_IDLE;
                                tcnt_reg  <= '0;
                                bars_reg  <= '0;
                            end else begin
                                tcnt_reg <= tcnt_reg + TCNT_W'(1);
                            end
                        end
                    end
                    ST_IDLE: begin
                        if (level_valid_i && level_nz) begin
                            state_reg <= ST_TRACK;
                            bars_reg  <= therm;
                            tcnt_reg  <= '0;
                        end else if (tick) begin
                            if (tcnt_reg == TCNT_W'(HB_PERIOD_TICKS - 1)) begin
                                tcnt_reg <= '0;
                            end else begin
                                tcnt_reg <= tcnt_reg + TCNT_W'(1);
                            end
                        end
                    end
                    ST_TRACK: begin
                        if (level_valid_i) begin
                            tcnt_reg <= '0;
                            if (level_nz) begin
                                bars_reg <= therm;
                            end else begin
                                state_reg <= ST_IDLE;
                                bars_reg  <= '0;
                            end
                        end else if (tick) begin
                            if (tcnt_reg == TCNT_W'(LOST_TIMEOUT_TICKS - 1)) begin
                                state_reg <= ST_LOST;
                                tcnt_reg  <= '0;
                            end else begin
                                tcnt_reg <= tcnt_reg + TCNT_W'(1);
                            end
                        end
                    end
                    ST_LOST: begin
                        if (level_valid_i) begin
                            tcnt_reg <= '0;
                            if (level_nz) begin
                                state_reg <= ST_TRACK;
                                bars_reg  <= therm;
                            end else begin
                                state_reg <= ST_IDLE;
                                bars_reg  <= '0;
                            end
                        end else if (tick) begin
                            if (tcnt_reg == TCNT_W'(LOST_HOLD_TICKS - 1)) begin
                                state_reg <= ST_IDLE;
                                tcnt_reg  <= '0;
                                bars_reg  <= '0;
                            end else begin
                                tcnt_reg <= tcnt_reg + TCNT_W'(1);
                            end
                        end
                    end
                    ST_FAULT: begin
                        state_reg <= ST_IDLE;
                        tcnt_reg  <= '0;
                        bars_reg  <= '0;
                    end
                    default: begin
                        state_reg <= ST_BOOT;
                        tcnt_reg  <= '0;
                        bars_reg  <= '0;
                    end
                endcase
            end
        end
    end

    assign led_o    = led_reg;
    assign led0_r_o = r_reg;
    assign led0_g_o = g_reg;
    assign led0_b_o = b_reg;

endmodule

// File: tb/tb_led_status_sequencer.sv
// Scoreboard bench: stimulus queues expected LED requests per clock index,
// a negedge monitor pops and compares them.
module tb_led_status_sequencer;

    logic       clk;
    logic       rst;
    logic       level_valid;
    logic [3:0] level;
    logic       fault;
    logic [3:0] led;
    logic       led_r;
    logic       led_g;
    logic       led_b;

    typedef struct {
        int         cyc;
        string      name;
        logic [6:0] exp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   abs_cyc = 0;
    int   base    = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    led_status_sequencer #(
        .CLK_FREQ           (1000),
        .TICK_HZ            (100),
        .LEVEL_W            (4),
        .BOOT_STEPS         (8),
        .HB_PERIOD_TICKS    (10),
        .HB_ON_TICKS        (2),
        .LOST_TIMEOUT_TICKS (5),
        .LOST_HOLD_TICKS    (6),
        .BLINK_TICKS        (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .level_valid_i (level_valid),
        .level_i       (level),
        .fault_i       (fault),
        .led_o         (led),
        .led0_r_o      (led_r),
        .led0_g_o      (led_g),
        .led0_b_o      (led_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) abs_cyc <= abs_cyc + 1;

    task automatic expect_abs(input int c, input string name, input logic [3:0] l,
                              input logic r, input logic g, input logic b);
        exp_t e;
        e.cyc  = c;
        e.name = name;
        e.exp  = {l, r, g, b};
        sb_q.push_back(e);
    endtask

    // k = index of the clock edge after release whose result is sampled.
    task automatic expect_k(input int k, input string name, input logic [3:0] l,
                            input logic r, input logic g, input logic b);
        expect_abs(base + 1 + k, name, l, r, g, b);
    endtask

    task automatic goto_neg(input int k);
        while (abs_cyc < base + 1 + k) @(negedge clk);
    endtask

    task automatic send(input int k, input logic [3:0] lvl);
        goto_neg(k - 1);
        level_valid = 1'b1;
        level       = lvl;
        goto_neg(k);
        level_valid = 1'b0;
        level       = 4'd0;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= abs_cyc) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            if (mon_e.cyc != abs_cyc) begin
                n_err++;
                $display("FAIL %s: sample point %0d missed, now %0d", mon_e.name, mon_e.cyc, abs_cyc);
            end else if ({led, led_r, led_g, led_b} !== mon_e.exp) begin
                n_err++;
                $display("FAIL %s: got led=%b rgb=%b%b%b, expected led=%b rgb=%b",
                         mon_e.name, led, led_r, led_g, led_b, mon_e.exp[6:3], mon_e.exp[2:0]);
            end else begin
                $display("ok   %s: led=%b rgb=%b%b%b", mon_e.name, led, led_r, led_g, led_b);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        level_valid = 1'b0;
        level       = 4'd0;
        fault       = 1'b0;
        expect_abs(2, "reset_state", 4'b0000, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        base = abs_cyc;

        expect_k(0,   "boot_step0",        4'b0001, 0, 0, 1);
        expect_k(9,   "boot_step0_end",    4'b0001, 0, 0, 1);
        expect_k(10,  "boot_step1",        4'b0010, 0, 0, 1);
        expect_k(20,  "boot_step2",        4'b0100, 0, 0, 1);
        expect_k(30,  "boot_step3",        4'b1000, 0, 0, 1);
        expect_k(40,  "boot_step4_wrap",   4'b0001, 0, 0, 1);
        expect_k(79,  "boot_step7",        4'b1000, 0, 0, 1);
        expect_k(80,  "idle_hb_on",        4'b0000, 0, 1, 0);
        expect_k(99,  "idle_hb_on_last",   4'b0000, 0, 1, 0);
        expect_k(100, "idle_hb_off",       4'b0000, 0, 0, 0);
        expect_k(179, "idle_hb_prewrap",   4'b0000, 0, 0, 0);
        expect_k(180, "idle_hb_wrap",      4'b0000, 0, 1, 0);
        expect_k(185, "idle_pre_valid",    4'b0000, 0, 1, 0);
        expect_k(186, "track_lvl9",        4'b0111, 1, 1, 0);
        expect_k(190, "track_lvl9_hold",   4'b0111, 1, 1, 0);
        expect_k(191, "track_lvl13",       4'b1111, 0, 1, 0);
        expect_k(196, "track_lvl2",        4'b0001, 1, 1, 0);
        expect_k(201, "track_lvl9_again",  4'b0111, 1, 1, 0);
        expect_k(249, "track_pre_timeout", 4'b0111, 1, 1, 0);
        expect_k(250, "lost_blink_off",    4'b0000, 0, 0, 0);
        expect_k(260, "lost_blink_on",     4'b0111, 1, 0, 0);
        expect_k(279, "lost_blink_on_end", 4'b0111, 1, 0, 0);
        expect_k(280, "lost_blink_off2",   4'b0000, 0, 0, 0);
        expect_k(300, "lost_blink_on2",    4'b0111, 1, 0, 0);
        expect_k(309, "lost_last",         4'b0111, 1, 0, 0);
        expect_k(310, "lost_hold_to_idle", 4'b0000, 0, 1, 0);
        expect_k(316, "track_lvl9_c",      4'b0111, 1, 1, 0);
        expect_k(356, "track_lvl5",        4'b0011, 1, 1, 0);
        expect_k(360, "track_restarted",   4'b0011, 1, 1, 0);
        expect_k(399, "track_restart_end", 4'b0011, 1, 1, 0);
        expect_k(400, "lost_after_restart",4'b0000, 0, 0, 0);
        expect_k(405, "lost_pre_valid",    4'b0000, 0, 0, 0);
        expect_k(406, "lost_lvl12_track",  4'b1111, 0, 1, 0);
        expect_k(412, "track_pre_zero",    4'b1111, 0, 1, 0);
        expect_k(413, "track_lvl0_idle",   4'b0000, 0, 1, 0);
        expect_k(426, "track_lvl13_b",     4'b1111, 0, 1, 0);
        expect_k(429, "track_pre_reset",   4'b1111, 0, 1, 0);
        expect_k(430, "async_reset",       4'b0000, 0, 0, 0);

        send(185, 4'd9);
        send(190, 4'd13);
        send(195, 4'd2);
        send(200, 4'd9);
        send(315, 4'd9);
        send(355, 4'd5);
        send(405, 4'd12);
        send(412, 4'd0);
        send(425, 4'd13);
        goto_neg(429);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        base = abs_cyc;

        expect_k(0,   "reboot_step0",      4'b0001, 0, 0, 1);
        expect_k(15,  "reboot_pre_fault",  4'b0010, 0, 0, 1);
        expect_k(16,  "fault_entry",       4'b0000, 0, 0, 0);
        expect_k(20,  "fault_blink_on",    4'b0000, 1, 0, 0);
        expect_k(26,  "fault_ignores_valid",4'b0000, 1, 0, 0);
        expect_k(39,  "fault_blink_on_end",4'b0000, 1, 0, 0);
        expect_k(40,  "fault_blink_off",   4'b0000, 0, 0, 0);
        expect_k(60,  "fault_blink_on2",   4'b0000, 1, 0, 0);
        expect_k(65,  "fault_last",        4'b0000, 1, 0, 0);
        expect_k(66,  "fault_to_idle",     4'b0000, 0, 1, 0);
        expect_k(79,  "idle_b_hb_on",      4'b0000, 0, 1, 0);
        expect_k(80,  "idle_b_hb_off",     4'b0000, 0, 0, 0);
        expect_k(159, "idle_b_prewrap",    4'b0000, 0, 0, 0);
        expect_k(160, "idle_b_wrap",       4'b0000, 0, 1, 0);

        goto_neg(14);
        fault       = 1'b1;
        level_valid = 1'b1;
        level       = 4'd9;
        goto_neg(15);
        level_valid = 1'b0;
        level       = 4'd0;
        send(25, 4'd13);
        goto_neg(64);
        fault = 1'b0;
        goto_neg(165);

        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s: sample point %0d never reached, now %0d", mon_e.name, mon_e.cyc, abs_cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
